// File: rtl/uart_ctrl.sv
// uart_ctrl: full-duplex 8N1 UART with 16-deep RX/TX byte FIFOs between board pins and fabric.
// Handshake: a byte moves on a clk edge only when valid and ready are both high at that edge.

module uart_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full
);
  logic [7:0] r_mem [16];
  logic [3:0] r_wptr;
  logic [3:0] r_rptr;
  logic       r_full;
  logic       r_empty;
  logic       w_wr;
  logic       w_rd;

  // A push while full is taken only when a pop frees the head slot on the same edge.
  assign w_rd = i_pop && !r_empty;
  assign w_wr = i_push && (!r_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= 4'd0;
      r_rptr  <= 4'd0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 4'd1;
      if (w_rd) r_rptr <= r_rptr + 4'd1;
      if (w_wr && !w_rd) begin
        r_empty <= 1'b0;
        r_full  <= ((r_wptr + 4'd1) == r_rptr);
      end else if (w_rd && !w_wr) begin
        r_full  <= 1'b0;
        r_empty <= ((r_rptr + 4'd1) == r_wptr);
      end
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;
endmodule

module uart_ctrl #(
  parameter string DEVICE    = "7SERIES",
  parameter int    CLK_FREQ  = 100000000,
  parameter int    BAUD_RATE = 115200,
  parameter string UART_MODE = "NORMAL"
) (
  input  logic       clk,
  input  logic       rst,
  output logic       uart_ready,
  output logic [7:0] uart_rd_data,
  output logic       uart_rd_valid,
  input  logic       uart_rd_ready,
  input  logic [7:0] uart_wr_data,
  input  logic       uart_wr_valid,
  output logic       uart_wr_ready,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [1:0] o_rx_state,
  output logic [1:0] o_tx_state
);
  localparam int DIV   = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam bit LOOPBACK = (UART_MODE == "LOOPBACK");

  generate
    if (DEVICE != "7SERIES" && DEVICE != "GENERIC") begin : g_bad_device
      $error("uart_ctrl: unsupported DEVICE value");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [3:0] r_init_cnt;
  logic       r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_cnt <= 4'd0;
      r_ready    <= 1'b0;
    end else if (!r_ready) begin
      r_init_cnt <= r_init_cnt + 4'd1;
      if (r_init_cnt == 4'd15) r_ready <= 1'b1;
    end
  end

  // ---------------- RX path ----------------
  logic             r_tx_line;
  logic             w_rx_in;
  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_prev;
  state_t           r_rx_state;
  state_t           w_rx_state_nxt;
  logic [DIV_W-1:0] r_rx_div;
  logic [3:0]       r_rx_tick;
  logic [3:0]       w_rx_tick_nxt;
  logic [2:0]       r_rx_bit;
  logic [2:0]       w_rx_bit_nxt;
  logic [7:0]       r_rx_shift;
  logic [7:0]       w_rx_shift_nxt;
  logic             w_rx_tick;
  logic             w_rx_push;
  logic             w_rx_empty;
  logic             w_rx_full;
  logic [7:0]       w_rx_head;

  assign w_rx_in   = LOOPBACK ? r_tx_line : uart_rxd;
  assign w_rx_tick = (r_rx_div == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_div   <= '0;
      r_rx_tick  <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      r_rx_s1    <= w_rx_in;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_div   <= (r_rx_state == ST_IDLE || w_rx_tick) ? '0 : r_rx_div + 1'b1;
      r_rx_tick  <= w_rx_tick_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Start needs a true 1->0 edge, so after a framing error the line must return high first.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tick_nxt  = r_rx_tick;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_tick_nxt = 4'd0;
        w_rx_bit_nxt  = 3'd0;
        if (r_rx_prev && !r_rx_s2) w_rx_state_nxt = ST_START;
      end
      ST_START: if (w_rx_tick) begin
        w_rx_tick_nxt = r_rx_tick + 4'd1;
        if (r_rx_tick == 4'd7) begin
          w_rx_tick_nxt  = 4'd0;
          w_rx_state_nxt = r_rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: if (w_rx_tick) begin
        w_rx_tick_nxt = r_rx_tick + 4'd1;
        if (r_rx_tick == 4'd15) begin
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = ST_STOP;
        end
      end
      ST_STOP: if (w_rx_tick) begin
        w_rx_tick_nxt = r_rx_tick + 4'd1;
        if (r_rx_tick == 4'd15) begin
          w_rx_push      = r_rx_s2;
          w_rx_state_nxt = ST_IDLE;
        end
      end
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  uart_fifo u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push && !w_rx_full),
    .i_data  (r_rx_shift),
    .i_pop   (uart_rd_ready),
    .o_data  (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  assign uart_rd_valid = !w_rx_empty;
  assign uart_rd_data  = w_rx_empty ? 8'h00 : w_rx_head;

  // ---------------- TX path ----------------
  state_t           r_tx_state;
  state_t           w_tx_state_nxt;
  logic [DIV_W-1:0] r_tx_div;
  logic [3:0]       r_tx_tick;
  logic [3:0]       w_tx_tick_nxt;
  logic [2:0]       r_tx_bit;
  logic [2:0]       w_tx_bit_nxt;
  logic [7:0]       r_tx_shift;
  logic [7:0]       w_tx_shift_nxt;
  logic             w_tx_line_nxt;
  logic             w_tx_tick;
  logic             w_tx_pop;
  logic             w_tx_empty;
  logic             w_tx_full;
  logic [7:0]       w_tx_head;

  assign w_tx_tick     = (r_tx_div == DIV_W'(DIV - 1));
  assign uart_wr_ready = r_ready && !w_tx_full;

  uart_fifo u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (uart_wr_valid && uart_wr_ready),
    .i_data  (uart_wr_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= ST_IDLE;
      r_tx_div   <= '0;
      r_tx_tick  <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_div   <= (r_tx_state == ST_IDLE || w_tx_tick) ? '0 : r_tx_div + 1'b1;
      r_tx_tick  <= w_tx_tick_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_line  <= w_tx_line_nxt;
    end
  end

  // STOP hands straight over to the next START so queued bytes go out with no idle gap.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_tick_nxt  = r_tx_tick;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_pop       = 1'b0;
    w_tx_line_nxt  = 1'b1;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_tick_nxt = 4'd0;
        w_tx_bit_nxt  = 3'd0;
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_head;
          w_tx_state_nxt = ST_START;
        end
      end
      ST_START: if (w_tx_tick) begin
        w_tx_tick_nxt = r_tx_tick + 4'd1;
        if (r_tx_tick == 4'd15) w_tx_state_nxt = ST_DATA;
      end
      ST_DATA: if (w_tx_tick) begin
        w_tx_tick_nxt = r_tx_tick + 4'd1;
        if (r_tx_tick == 4'd15) begin
          w_tx_shift_nxt = {1'b1, r_tx_shift[7:1]};
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_nxt = ST_STOP;
        end
      end
      ST_STOP: if (w_tx_tick) begin
        w_tx_tick_nxt = r_tx_tick + 4'd1;
        if (r_tx_tick == 4'd15) begin
          if (!w_tx_empty) begin
            w_tx_pop       = 1'b1;
            w_tx_shift_nxt = w_tx_head;
            w_tx_state_nxt = ST_START;
          end else begin
            w_tx_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
    case (w_tx_state_nxt)
      ST_START: w_tx_line_nxt = 1'b0;
      ST_DATA:  w_tx_line_nxt = w_tx_shift_nxt[0];
      default:  w_tx_line_nxt = 1'b1;
    endcase
  end

  assign uart_txd   = LOOPBACK ? 1'b1 : r_tx_line;
  assign uart_ready = r_ready;
  assign o_rx_state = r_rx_state;
  assign o_tx_state = r_tx_state;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed checks of uart_ctrl at a fast baud (DIV=2, 32 clks per bit) so the
// full scenario list fits a short run; a second instance covers LOOPBACK mode.

module tb_uart_ctrl;
  localparam int CLK_FREQ  = 4000000;
  localparam int BAUD      = 115200;
  localparam int BIT       = 32;
  localparam int RD_PERIOD = 37;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       uart_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       rxd      = 1'b1;
  logic       txd;
  logic [1:0] rx_state;
  logic [1:0] tx_state;

  logic       lb_ready;
  logic [7:0] lb_rd_data;
  logic       lb_rd_valid;
  logic       lb_rd_ready = 1'b0;
  logic [7:0] lb_wr_data  = 8'h00;
  logic       lb_wr_valid = 1'b0;
  logic       lb_wr_ready;
  logic       lb_rxd      = 1'b0;
  logic       lb_txd;
  logic [1:0] lb_rx_state;
  logic [1:0] lb_tx_state;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  uart_ctrl #(.DEVICE("7SERIES"), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .UART_MODE("NORMAL")) u_dut (
    .clk(clk), .rst(rst), .uart_ready(uart_ready),
    .uart_rd_data(rd_data), .uart_rd_valid(rd_valid), .uart_rd_ready(rd_ready),
    .uart_wr_data(wr_data), .uart_wr_valid(wr_valid), .uart_wr_ready(wr_ready),
    .uart_rxd(rxd), .uart_txd(txd), .o_rx_state(rx_state), .o_tx_state(tx_state)
  );

  uart_ctrl #(.DEVICE("GENERIC"), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .UART_MODE("LOOPBACK")) u_lb (
    .clk(clk), .rst(rst), .uart_ready(lb_ready),
    .uart_rd_data(lb_rd_data), .uart_rd_valid(lb_rd_valid), .uart_rd_ready(lb_rd_ready),
    .uart_wr_data(lb_wr_data), .uart_wr_valid(lb_wr_valid), .uart_wr_ready(lb_wr_ready),
    .uart_rxd(lb_rxd), .uart_txd(lb_txd), .o_rx_state(lb_rx_state), .o_tx_state(lb_tx_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_checks++; if (uart_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", uart_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_checks++; if (lb_txd !== 1'b1) begin n_fail++; $display("FAIL reset_lb_txd: got %b want 1", lb_txd); end
    rst = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++; if (uart_ready !== 1'b0) begin n_fail++; $display("FAIL ready_early: got %b want 0 after 15 clks", uart_ready); end
    @(negedge clk);
    n_checks++; if (uart_ready !== 1'b1) begin n_fail++; $display("FAIL ready_16: got %b want 1 after 16 clks", uart_ready); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after_init: got %b want 1", wr_ready); end
    n_checks++; if (lb_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready_16: got %b want 1", lb_ready); end
  endtask

  task automatic test_single_rx();
    logic [7:0] d;
    int         lat;
    d   = 8'hA5;
    lat = -1;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    for (int k = 0; k <= 3; k++) begin
      if (rd_valid === 1'b1) begin lat = k; break; end
      if (k < 3) @(negedge clk);
    end
    n_checks++; if (lat < 0) begin n_fail++; $display("FAIL rx_single_latency: rd_valid %b, want 1 within 3 clks of stop centre", rd_valid); end
    n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL rx_single_data: got %h want a5", rd_data); end
    pop_one();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rx_single_pop: rd_valid %b want 0", rd_valid); end
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_stream();
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    fork
      begin
        for (int i = 0; i < 128; i++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          send_byte(b, 1'b1);
        end
      end
      begin
        while (got < 128 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          rd_ready = 1'b0;
          if (cyc % RD_PERIOD == 0) begin
            if (rd_valid === 1'b1) begin
              n_checks++;
              if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL stream_extra: got %h with nothing expected", rd_data);
              end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin n_fail++; $display("FAIL stream_byte %0d: got %h want %h", got, rd_data, e); end
              end
              got++;
            end
            rd_ready = 1'b1;
          end
        end
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    n_checks++; if (got != 128) begin n_fail++; $display("FAIL stream_count: got %0d bytes want 128", got); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_left: %0d bytes not received, want 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [7:0] d0;
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_byte(8'(i * 13 + 1), 1'b1);
    repeat (4) @(negedge clk);
    d0 = rd_data;
    repeat (10) @(negedge clk);
    n_checks++; if (rd_data !== d0 || d0 !== 8'h01) begin n_fail++; $display("FAIL ovf_stable: got %h then %h want 01", d0, rd_data); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i * 13 + 1)) begin
        n_fail++; $display("FAIL ovf_byte %0d: valid %b data %h want 1 %h", i, rd_valid, rd_data, 8'(i * 13 + 1));
      end
      pop_one();
    end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: rd_valid %b data %h want 0 (byte 16 dropped)", rd_valid, rd_data); end
  endtask

  task automatic test_framing();
    send_byte(8'h3C, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL framing_push: rd_valid %b want 0", rd_valid); end
    n_checks++; if (rx_state !== 2'd0) begin n_fail++; $display("FAIL framing_idle: rx_state %0d want 0", rx_state); end
    send_byte(8'hC3, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin n_fail++; $display("FAIL framing_rearm: valid %b data %h want 1 c3", rd_valid, rd_data); end
    pop_one();
  endtask

  task automatic test_false_start();
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    n_checks++; if (rx_state !== 2'd1) begin n_fail++; $display("FAIL false_start_enter: rx_state %0d want 1", rx_state); end
    repeat (40) @(negedge clk);
    n_checks++; if (rx_state !== 2'd0) begin n_fail++; $display("FAIL false_start_idle: rx_state %0d want 0", rx_state); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_push: rd_valid %b want 0", rd_valid); end
  endtask

  task automatic test_tx_single();
    logic [9:0] frame;
    int         k;
    int         bad;
    frame    = {1'b1, 8'h3C, 1'b0};
    wr_data  = 8'h3C;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    k = 0;
    while (txd !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    n_checks++; if (k >= 10) begin n_fail++; $display("FAIL tx_single_start: txd %b want 0 within 10 clks", txd); end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int s = 0; s < BIT; s++) begin
        if (txd !== frame[b]) bad++;
        @(negedge clk);
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL tx_single_bit %0d: %0d of %0d samples wrong, want %b", b, bad, BIT, frame[b]); end
    end
    repeat (4) @(negedge clk);
    n_checks++; if (txd !== 1'b1 || tx_state !== 2'd0) begin n_fail++; $display("FAIL tx_single_idle: txd %b state %0d want 1 0", txd, tx_state); end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          int w;
          w = 0;
          wr_data  = 8'(i * 37 + 5);
          wr_valid = 1'b1;
          while (wr_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
          n_checks++; if (w >= 2000) begin n_fail++; $display("FAIL tx_wr_timeout %0d: wr_ready %b want 1", i, wr_ready); end
          @(negedge clk);
        end
        wr_valid = 1'b0;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL tx_full: wr_ready %b want 0 with 16 queued", wr_ready); end
      end
      begin
        int k;
        int bad;
        logic [9:0] frame;
        k = 0;
        while (txd !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        n_checks++; if (k >= 100) begin n_fail++; $display("FAIL tx_queue_start: txd %b want 0", txd); end
        for (int f = 0; f < 17; f++) begin
          frame = {1'b1, 8'(f * 37 + 5), 1'b0};
          bad = 0;
          for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < BIT; s++) begin
              if (txd !== frame[b]) bad++;
              @(negedge clk);
            end
          end
          n_checks++; if (bad != 0) begin n_fail++; $display("FAIL tx_queue_frame %0d: %0d samples wrong, want frame %b", f, bad, frame); end
        end
      end
    join
    repeat (4) @(negedge clk);
    n_checks++; if (txd !== 1'b1 || tx_state !== 2'd0) begin n_fail++; $display("FAIL tx_queue_idle: txd %b state %0d want 1 0", txd, tx_state); end
  endtask

  task automatic test_loopback();
    int k;
    int bad;
    lb_wr_data  = 8'h5A;
    lb_wr_valid = 1'b1;
    @(negedge clk);
    lb_wr_valid = 1'b0;
    k   = 0;
    bad = 0;
    while (lb_rd_valid !== 1'b1 && k < 1000) begin
      if (lb_txd !== 1'b1) bad++;
      @(negedge clk);
      k++;
    end
    n_checks++; if (k >= 1000) begin n_fail++; $display("FAIL lb_timeout: lb_rd_valid %b want 1", lb_rd_valid); end
    n_checks++; if (lb_rd_data !== 8'h5A) begin n_fail++; $display("FAIL lb_data: got %h want 5a", lb_rd_data); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lb_txd_held: %0d samples of txd low, want 0", bad); end
    lb_rd_ready = 1'b1;
    @(negedge clk);
    lb_rd_ready = 1'b0;
    n_checks++; if (lb_rd_valid !== 1'b0) begin n_fail++; $display("FAIL lb_pop: lb_rd_valid %b want 0", lb_rd_valid); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_rx();
    test_stream();
    test_overflow();
    test_framing();
    test_false_start();
    test_tx_single();
    test_back_to_back();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
